trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer: the write side of the CSR file's secondary (clint_*) port. Takes ecall/ebreak
//  from decode, timer/external IRQs and mret, and sequences mepc/mcause/mstatus writes.
//  Stalls the pipeline for the whole sequence, then redirects the PC to mtvec or mepc.
// PARAMETERS
//  TRAP_BASE_CAUSE_TMR  32'h8000_0007  mcause value for a timer interrupt
//  TRAP_BASE_CAUSE_EXT  32'h8000_000B  mcause value for an external interrupt
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  inst_valid_i    in   1   decode stage holds a real instruction (not a bubble)
//  inst_addr_i     in   32  PC of the instruction in decode
//  ecall_i         in   1   decode instruction is ecall
//  ebreak_i        in   1   decode instruction is ebreak
//  mret_i          in   1   decode instruction is mret
//  jump_flag_i     in   1   ex is redirecting the PC this cycle
//  jump_addr_i     in   32  ex redirect target
//  timer_irq_i     in   1   timer interrupt request, level
//  ext_irq_i       in   1   external interrupt request, level
//  global_int_en_i in   1   mstatus.MIE from the CSR file
//  csr_mtvec_i     in   32  current mtvec
//  csr_mepc_i      in   32  current mepc
//  csr_mstatus_i   in   32  current mstatus
//  csr_we_o        out  1   CSR write enable (csr_reg clint_we_i)
//  csr_waddr_o     out  32  CSR write address; upper 20 bits are 0
//  csr_wdata_o     out  32  CSR write data
//  hold_o          out  1   pipeline stall request
//  int_assert_o    out  1   one-cycle PC redirect strobe
//  int_addr_o      out  32  PC redirect target, valid while int_assert_o=1
// BEHAVIOUR
//  Reset: state=IDLE; csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, int_assert_o=0, int_addr_o=0, hold_o=0.
//  Reset mid-sequence: aborts at the next edge, back to IDLE; partial CSR writes are not undone.
//  Detection happens only in IDLE with inst_valid_i=1. Priority order:
//    1. ecall
//    2. ebreak
//    3. mret
//    4. ext_irq, when global_int_en_i=1
//    5. timer_irq, when global_int_en_i=1
//  Latched at detection:
//    cause: ecall=11, ebreak=3, or the parameter value
//    epc, exceptions: inst_addr_i
//    epc, interrupts: jump_addr_i if jump_flag_i, else inst_addr_i
//  hold_o = (state!=IDLE) | trap detected this cycle. Combinational; forced 0 while rst=1.
//  Trap sequence (detect at cycle T, state IDLE):
//    T+1 WR_MEPC:    we=1, waddr=12'h341, wdata=epc
//    T+2 WR_MCAUSE:  we=1, waddr=12'h342, wdata=cause
//    T+3 WR_MSTATUS: we=1, waddr=12'h300,
//                    wdata=csr_mstatus_i with bit7(MPIE)<=bit3(MIE), bit3<=0
//    T+4 JUMP:       we=0, int_assert_o=1, int_addr_o=target (see CONFIGURATION), then IDLE
//  mret sequence (detect at T):
//    T+1 MRET_MSTATUS: we=1, waddr=12'h300, wdata=csr_mstatus_i with bit3<=bit7, bit7<=1
//    T+2 JUMP:         int_assert_o=1, int_addr_o=csr_mepc_i, then IDLE
//  Outputs are registered. csr_we_o is high for exactly one cycle per write.
//  Only one write per cycle. Pipeline held, so ex never writes CSRs concurrently.
//  Boundary conditions:
//    - IRQs are levels; any request not taken stays pending and is re-evaluated in IDLE.
//    - IRQ raised in the same cycle as ecall/ebreak/mret: the synchronous event wins.
//    - IRQ raised during any non-IDLE state: ignored until IDLE.
//    - inst_valid_i=0 (bubble): nothing is taken; IRQs wait.
//    - jump_flag_i with an exception in the same cycle: exception epc stays inst_addr_i.
// CONFIGURATION
//  VECTORED_INT_EN defined:
//    - interrupt with csr_mtvec_i[1:0]==2'b01: target = {mtvec[31:2],2'b00} + 4*cause[30:0]
//    - exceptions, and mode 00: target = {mtvec[31:2],2'b00}
//  VECTORED_INT_EN undefined: target is always {mtvec[31:2],2'b00}; mode bits ignored.
// TESTING
//  1. ecall, inst_addr=0x100, mtvec=0x200, mstatus=0x8:
//     -> writes 341=0x100, 342=11, 300=0x80 on T+1..T+3; T+4 int_addr=0x200; hold T..T+4.
//  2. mret, mepc=0x104, mstatus=0x80:
//     -> T+1 write 300=0x88; T+2 int_addr=0x104; hold T..T+2.
//  3. timer_irq, MIE=1, jump_flag=1, jump_addr=0x300:
//     -> mepc=0x300, mcause=0x80000007.
//     Repeat with MIE=0: no hold, no writes.
//  4. ecall and ext_irq in the same cycle, MIE=1:
//     -> ecall sequence only; after return with MIE restored, ext trap with mcause=0x8000000B.
//  5. rst=1 at T+2 of a trap:
//     -> next cycle IDLE, all outputs 0; mepc written, mcause/mstatus unchanged.
//  6. VECTORED_INT_EN, mtvec=0x201, ext_irq:
//     -> int_addr=0x22C. Without the macro: int_addr=0x200.

Source files
------------

// File: rtl/trap_ctrl.sv
// ============================================================================
// trap_ctrl: trap/mret sequencer driving the CSR file's clint write port.
// Optional feature macro: VECTORED_INT_EN (vectored interrupt targets).
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_ctrl #(
  parameter logic [31:0] TRAP_BASE_CAUSE_TMR = 32'h8000_0007,
  parameter logic [31:0] TRAP_BASE_CAUSE_EXT = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_MEPC      = 3'd1,
    S_WR_MCAUSE    = 3'd2,
    S_WR_MSTATUS   = 3'd3,
    S_MRET_MSTATUS = 3'd4,
    S_JUMP         = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic        is_int_q, is_int_d;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_waddr_q, csr_waddr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;

  logic        take_exc, take_mret, take_ext, take_tmr, take_trap;
  logic [31:0] mstatus_trap, mstatus_mret, mtvec_base, trap_target;
  logic        unused_mode;

  // Fixed priority: ecall > ebreak > mret > ext irq > timer irq.
  assign take_exc  = inst_valid_i & (ecall_i | ebreak_i);
  assign take_mret = inst_valid_i & ~ecall_i & ~ebreak_i & mret_i;
  assign take_ext  = inst_valid_i & ~ecall_i & ~ebreak_i & ~mret_i
                     & global_int_en_i & ext_irq_i;
  assign take_tmr  = inst_valid_i & ~ecall_i & ~ebreak_i & ~mret_i
                     & global_int_en_i & ~ext_irq_i & timer_irq_i;
  assign take_trap = take_exc | take_ext | take_tmr;

  assign mstatus_trap = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                         1'b0, csr_mstatus_i[2:0]};
  assign mstatus_mret = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                         csr_mstatus_i[7], csr_mstatus_i[2:0]};
  assign mtvec_base   = {csr_mtvec_i[31:2], 2'b00};

`ifdef VECTORED_INT_EN
  assign trap_target = (is_int_q && csr_mtvec_i[1:0] == 2'b01)
                     ? mtvec_base + {cause_q[29:0], 2'b00}
                     : mtvec_base;
  assign unused_mode = 1'b0;
`else
  assign trap_target = mtvec_base;
  assign unused_mode = ^{csr_mtvec_i[1:0], is_int_q};
`endif

  assign hold_o = ~rst & ((state_q != S_IDLE) | take_trap | take_mret);

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    is_int_d     = is_int_q;
    csr_we_d     = 1'b0;
    csr_waddr_d  = 12'h000;
    csr_wdata_d  = 32'h0;
    int_assert_d = 1'b0;
    int_addr_d   = 32'h0;
    // Output registers are loaded with the values for the state being entered.
    case (state_q)
      S_IDLE: begin
        if (take_trap) begin
          state_d     = S_WR_MEPC;
          csr_we_d    = 1'b1;
          csr_waddr_d = CSR_MEPC;
          csr_wdata_d = (!take_exc && jump_flag_i) ? jump_addr_i : inst_addr_i;
          is_int_d    = ~take_exc;
          cause_d     = ecall_i  ? 32'd11 :
                        ebreak_i ? 32'd3  :
                        take_ext ? TRAP_BASE_CAUSE_EXT : TRAP_BASE_CAUSE_TMR;
        end else if (take_mret) begin
          state_d     = S_MRET_MSTATUS;
          csr_we_d    = 1'b1;
          csr_waddr_d = CSR_MSTATUS;
          csr_wdata_d = mstatus_mret;
        end
      end
      S_WR_MEPC: begin
        state_d     = S_WR_MCAUSE;
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MCAUSE;
        csr_wdata_d = cause_q;
      end
      S_WR_MCAUSE: begin
        state_d     = S_WR_MSTATUS;
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MSTATUS;
        csr_wdata_d = mstatus_trap;
      end
      S_WR_MSTATUS: begin
        state_d      = S_JUMP;
        int_assert_d = 1'b1;
        int_addr_d   = trap_target;
      end
      S_MRET_MSTATUS: begin
        state_d      = S_JUMP;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
      end
      S_JUMP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cause_q      <= 32'h0;
      is_int_q     <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= 12'h000;
      csr_wdata_q  <= 32'h0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      is_int_q     <= is_int_d;
      csr_we_q     <= csr_we_d;
      csr_waddr_q  <= csr_waddr_d;
      csr_wdata_q  <= csr_wdata_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign csr_we_o     = csr_we_q;
  assign csr_waddr_o  = {20'h00000, csr_waddr_q};
  assign csr_wdata_o  = csr_wdata_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a
// transaction-level reference model. Honours VECTORED_INT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, ecall_i, ebreak_i, mret_i, jump_flag_i;
  logic        timer_irq_i, ext_irq_i, global_int_en_i;
  logic [31:0] inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        csr_we_o, hold_o, int_assert_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, int_addr_o;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i),
    .global_int_en_i(global_int_en_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .hold_o(hold_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] ia;
    logic        ecall, ebreak, mret, jf;
    logic [31:0] ja;
    logic        tirq, eirq, mie;
    logic [31:0] mtvec, mepc, mstatus;
  } stim_t;

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [31:0] waddr, wdata;
    logic        ia;
    logic [31:0] iaddr;
  } out_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  out_t  exp_tr [6];
  out_t  obs_tr [6];
  int    exp_len;

  task automatic drive(input stim_t s);
    inst_valid_i    = s.valid;   inst_addr_i   = s.ia;
    ecall_i         = s.ecall;   ebreak_i      = s.ebreak;  mret_i = s.mret;
    jump_flag_i     = s.jf;      jump_addr_i   = s.ja;
    timer_irq_i     = s.tirq;    ext_irq_i     = s.eirq;
    global_int_en_i = s.mie;     csr_mtvec_i   = s.mtvec;
    csr_mepc_i      = s.mepc;    csr_mstatus_i = s.mstatus;
  endtask

  function automatic stim_t quiet(input stim_t s);
    stim_t r = '0;
    r.mtvec = s.mtvec; r.mepc = s.mepc; r.mstatus = s.mstatus;
    return r;
  endfunction

  function automatic stim_t noisy(input stim_t s);
    stim_t r = s;
    r.valid  = 1'($urandom); r.ecall = 1'($urandom); r.ebreak = 1'($urandom);
    r.mret   = 1'($urandom); r.jf    = 1'($urandom); r.tirq   = 1'($urandom);
    r.eirq   = 1'($urandom); r.mie   = 1'($urandom);
    r.ia     = $urandom;     r.ja    = $urandom;
    return r;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.hold = hold_o; o.we = csr_we_o; o.waddr = csr_waddr_o; o.wdata = csr_wdata_o;
    o.ia = int_assert_o; o.iaddr = int_addr_o;
    return o;
  endfunction

  // Reference model: expected per-cycle outputs for T..T+5 given the detect-cycle stimulus.
  task automatic model(input stim_t s);
    int          kind = 0;   // 0 none, 1 exception, 2 interrupt, 3 mret
    logic [31:0] cause = 0, epc, tgt;
    for (int k = 0; k < 6; k++) exp_tr[k] = '0;
    exp_len = 0;
    if (s.valid) begin
      if (s.ecall)               begin kind = 1; cause = 11; end
      else if (s.ebreak)         begin kind = 1; cause = 3; end
      else if (s.mret)           kind = 3;
      else if (s.mie && s.eirq)  begin kind = 2; cause = 32'h8000_000B; end
      else if (s.mie && s.tirq)  begin kind = 2; cause = 32'h8000_0007; end
    end
    tgt = s.mtvec & ~32'h3;
`ifdef VECTORED_INT_EN
    if (kind == 2 && s.mtvec[1:0] == 2'b01) tgt = tgt + 4 * (cause & 32'h7FFF_FFFF);
`endif
    if (kind == 1 || kind == 2) begin
      epc = (kind == 2 && s.jf) ? s.ja : s.ia;
      exp_len = 5;
      exp_tr[1].we = 1; exp_tr[1].waddr = 32'h341; exp_tr[1].wdata = epc;
      exp_tr[2].we = 1; exp_tr[2].waddr = 32'h342; exp_tr[2].wdata = cause;
      exp_tr[3].we = 1; exp_tr[3].waddr = 32'h300;
      exp_tr[3].wdata = (s.mstatus & ~32'h88) | (s.mstatus[3] ? 32'h80 : 32'h0);
      exp_tr[4].ia = 1; exp_tr[4].iaddr = tgt;
    end else if (kind == 3) begin
      exp_len = 3;
      exp_tr[1].we = 1; exp_tr[1].waddr = 32'h300;
      exp_tr[1].wdata = (s.mstatus & ~32'h8) | (s.mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
      exp_tr[2].ia = 1; exp_tr[2].iaddr = s.mepc;
    end
    for (int k = 0; k < exp_len; k++) exp_tr[k].hold = 1;
  endtask

  // Drives one transaction and records T..T+5; noise scrambles event inputs while busy.
  task automatic run_txn(input stim_t s, input bit noise);
    model(s);
    @(negedge clk); drive(s); #1 obs_tr[0] = sample();
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      if (k < exp_len) drive(noise ? noisy(s) : s);
      else             drive(quiet(s));
      #1 obs_tr[k] = sample();
    end
  endtask

  function automatic out_t mk(input logic h, input logic we, input logic [31:0] wa,
                              input logic [31:0] wd, input logic ia, input logic [31:0] iad);
    return '{hold: h, we: we, waddr: wa, wdata: wd, ia: ia, iaddr: iad};
  endfunction

  task automatic test_reset();
    stim_t s = '0;
    rst = 1; s.valid = 1; s.ecall = 1;
    @(negedge clk); drive(s); #1;
    n_tests++;
    if (hold_o !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", hold_o); end
    @(negedge clk); #1;
    n_tests++;
    if (sample() !== out_t'(0)) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", sample());
    end
    drive(quiet(s)); rst = 0;
  endtask

  task automatic test_ecall();
    stim_t s = '0;
    out_t  want [6];
    s.valid = 1; s.ia = 32'h100; s.ecall = 1; s.mtvec = 32'h200; s.mstatus = 32'h8;
    want[0] = mk(1, 0, 0, 0, 0, 0);
    want[1] = mk(1, 1, 32'h341, 32'h100, 0, 0);
    want[2] = mk(1, 1, 32'h342, 32'd11, 0, 0);
    want[3] = mk(1, 1, 32'h300, 32'h80, 0, 0);
    want[4] = mk(1, 0, 0, 0, 1, 32'h200);
    want[5] = mk(0, 0, 0, 0, 0, 0);
    run_txn(s, 0);
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (obs_tr[k] !== want[k]) begin
        n_fail++; $display("FAIL ecall c%0d: got %h want %h", k, obs_tr[k], want[k]);
      end
    end
  endtask

  task automatic test_mret();
    stim_t s = '0;
    out_t  want [4];
    s.valid = 1; s.ia = 32'h180; s.mret = 1; s.mepc = 32'h104; s.mstatus = 32'h80;
    s.mtvec = 32'h200;
    want[0] = mk(1, 0, 0, 0, 0, 0);
    want[1] = mk(1, 1, 32'h300, 32'h88, 0, 0);
    want[2] = mk(1, 0, 0, 0, 1, 32'h104);
    want[3] = mk(0, 0, 0, 0, 0, 0);
    run_txn(s, 0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (obs_tr[k] !== want[k]) begin
        n_fail++; $display("FAIL mret c%0d: got %h want %h", k, obs_tr[k], want[k]);
      end
    end
  endtask

  task automatic test_timer_irq();
    stim_t s = '0;
    s.valid = 1; s.ia = 32'h150; s.tirq = 1; s.mie = 1; s.jf = 1; s.ja = 32'h300;
    s.mtvec = 32'h200; s.mstatus = 32'h8;
    run_txn(s, 0);
    n_tests++;
    if (obs_tr[1] !== mk(1, 1, 32'h341, 32'h300, 0, 0)) begin
      n_fail++; $display("FAIL timer_mepc: got %h want mepc 0x300", obs_tr[1]);
    end
    n_tests++;
    if (obs_tr[2] !== mk(1, 1, 32'h342, 32'h8000_0007, 0, 0)) begin
      n_fail++; $display("FAIL timer_mcause: got %h want 0x80000007", obs_tr[2]);
    end
    // Masked interrupt and a bubble carrying ecall: neither may start a sequence.
    s.mie = 0;
    run_txn(s, 0);
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (obs_tr[k] !== out_t'(0)) begin
        n_fail++; $display("FAIL timer_masked c%0d: got %h want 0", k, obs_tr[k]);
      end
    end
    s.mie = 1; s.valid = 0; s.ecall = 1;
    run_txn(s, 0);
    n_tests++;
    if (obs_tr[0].hold !== 1'b0 || obs_tr[1] !== out_t'(0)) begin
      n_fail++; $display("FAIL bubble: got %h / %h want idle", obs_tr[0], obs_tr[1]);
    end
  endtask

  task automatic test_priority();
    stim_t s = '0;
    s.valid = 1; s.ia = 32'h120; s.ecall = 1; s.eirq = 1; s.mie = 1;
    s.mtvec = 32'h200; s.mstatus = 32'h8;
    run_txn(s, 0);
    n_tests++;
    if (obs_tr[2] !== mk(1, 1, 32'h342, 32'd11, 0, 0)) begin
      n_fail++; $display("FAIL prio_cause: got %h want mcause 11", obs_tr[2]);
    end
    n_tests++;
    if (obs_tr[4] !== mk(1, 0, 0, 0, 1, 32'h200) || obs_tr[5] !== out_t'(0)) begin
      n_fail++; $display("FAIL prio_end: got %h / %h want jump then idle", obs_tr[4], obs_tr[5]);
    end
    s.ecall = 0;
    run_txn(s, 0);
    n_tests++;
    if (obs_tr[2] !== mk(1, 1, 32'h342, 32'h8000_000B, 0, 0)) begin
      n_fail++; $display("FAIL prio_ext: got %h want mcause 0x8000000B", obs_tr[2]);
    end
  endtask

  task automatic test_reset_mid();
    stim_t s = '0;
    s.valid = 1; s.ia = 32'h400; s.ecall = 1; s.mtvec = 32'h200; s.mstatus = 32'h8;
    @(negedge clk); drive(s); #1;
    @(negedge clk); #1;
    n_tests++;
    if (sample() !== mk(1, 1, 32'h341, 32'h400, 0, 0)) begin
      n_fail++; $display("FAIL rstmid_mepc: got %h want mepc write 0x400", sample());
    end
    rst = 1; drive(quiet(s)); #1;
    n_tests++;
    if (hold_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold: got %b want 0", hold_o); end
    @(negedge clk); #1;
    n_tests++;
    if (sample() !== out_t'(0)) begin
      n_fail++; $display("FAIL rstmid_abort: got %h want 0", sample());
    end
    rst = 0;
    @(negedge clk); #1;
    n_tests++;
    if (sample() !== out_t'(0)) begin
      n_fail++; $display("FAIL rstmid_idle: got %h want 0", sample());
    end
  endtask

  task automatic test_vectored();
    stim_t       s = '0;
    logic [31:0] want_int;
`ifdef VECTORED_INT_EN
    want_int = 32'h22C;
`else
    want_int = 32'h200;
`endif
    s.valid = 1; s.ia = 32'h500; s.eirq = 1; s.mie = 1; s.mtvec = 32'h201; s.mstatus = 32'h8;
    run_txn(s, 0);
    n_tests++;
    if (obs_tr[4] !== mk(1, 0, 0, 0, 1, want_int)) begin
      n_fail++; $display("FAIL vec_ext: got %h want int_addr %h", obs_tr[4], want_int);
    end
    s.eirq = 0; s.ebreak = 1;
    run_txn(s, 0);
    n_tests++;
    if (obs_tr[4] !== mk(1, 0, 0, 0, 1, 32'h200)) begin
      n_fail++; $display("FAIL vec_exc: got %h want int_addr 0x200", obs_tr[4]);
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int t = 0; t < 60; t++) begin
      s.valid   = ($urandom_range(3) != 0);
      s.ecall   = ($urandom_range(5) == 0);
      s.ebreak  = ($urandom_range(5) == 0);
      s.mret    = ($urandom_range(4) == 0);
      s.jf      = 1'($urandom);
      s.tirq    = 1'($urandom);
      s.eirq    = 1'($urandom);
      s.mie     = 1'($urandom);
      s.ia      = $urandom & ~32'h3;
      s.ja      = $urandom & ~32'h3;
      s.mtvec   = ($urandom & ~32'h3) | 32'($urandom_range(1));
      s.mepc    = $urandom;
      s.mstatus = $urandom;
      run_txn(s, 1'($urandom));
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (obs_tr[k] !== exp_tr[k]) begin
          n_fail++; $display("FAIL random t%0d c%0d: got %h want %h", t, k, obs_tr[k], exp_tr[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1;
    drive('0);
    repeat (2) @(posedge clk);
    test_reset();
    test_ecall();
    test_mret();
    test_timer_irq();
    test_priority();
    test_reset_mid();
    test_vectored();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
